// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic datapath types and widths
package arith_pkg;

  localparam int DATA_WIDTH = 8;
  // Full product of two operands plus a carry bit, reduced by modulo_seq.
  localparam int PROD_WIDTH = 2 * DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } modulo_state_t;

endpackage

// File: rtl/cond_sub_step.sv
// rtl/cond_sub_step.sv - one restoring-division step: shift in a bit, compare, conditionally subtract
module cond_sub_step #(
  parameter int M_WIDTH = 8
) (
  input  logic [M_WIDTH-1:0] i_rem,
  input  logic               i_bit,
  input  logic [M_WIDTH-1:0] i_mod,
  output logic [M_WIDTH-1:0] o_rem,
  output logic               o_qbit
);

  logic [M_WIDTH:0] w_t;
  logic             w_ge;

  assign w_t  = {i_rem, i_bit};
  assign w_ge = (w_t >= {1'b0, i_mod});

  // The difference is always below the modulus, so M_WIDTH-bit wraparound is exact.
  assign o_rem  = w_ge ? (w_t[M_WIDTH-1:0] - i_mod) : w_t[M_WIDTH-1:0];
  assign o_qbit = w_ge;

endmodule

// File: rtl/modulo_seq.sv
// rtl/modulo_seq.sv - bit-serial remainder/quotient unit with valid/ready handshakes
module modulo_seq
  import arith_pkg::*;
#(
  parameter int A_WIDTH = PROD_WIDTH,
  parameter int M_WIDTH = DATA_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [M_WIDTH-1:0] modulant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [M_WIDTH-1:0] out,
  output logic [A_WIDTH-1:0] quotient,
  output logic               div_zero
);

  localparam int CNT_W = $clog2(A_WIDTH + 1);

  modulo_state_t      r_state;
  logic [M_WIDTH-1:0] r_rem;
  logic [M_WIDTH-1:0] r_mod;
  logic [A_WIDTH-1:0] r_div;
  logic [A_WIDTH-1:0] r_quo;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [M_WIDTH-1:0] r_out;
  logic [A_WIDTH-1:0] r_quotient;
  logic               r_div_zero;

  logic [M_WIDTH-1:0] w_rem_nxt;
  logic               w_qbit;
  logic [A_WIDTH-1:0] w_quo_nxt;

  cond_sub_step #(.M_WIDTH(M_WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_div[A_WIDTH-1]),
    .i_mod  (r_mod),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  assign w_quo_nxt = {r_quo[A_WIDTH-2:0], w_qbit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_mod       <= '0;
      r_div       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_quotient  <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mod      <= modulant;
            r_div      <= a;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= CNT_W'(A_WIDTH);
            r_in_ready <= 1'b0;
            if (modulant == '0) begin
              r_out       <= '0;
              r_quotient  <= '1;
              r_div_zero  <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (a < A_WIDTH'(modulant)) begin
              r_out       <= a[M_WIDTH-1:0];
              r_quotient  <= '0;
              r_div_zero  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_div <= {r_div[A_WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_out       <= w_rem_nxt;
            r_quotient  <= w_quo_nxt;
            r_div_zero  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign quotient  = r_quotient;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_modulo_seq.sv
// tb/tb_modulo_seq.sv - self-checking bench for modulo_seq
module tb_modulo_seq;

  localparam int AW = 17;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] a = '0;
  logic [MW-1:0] modulant = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [MW-1:0] out;
  logic [AW-1:0] quotient;
  logic          div_zero;

  int n_checks = 0;
  int n_errors = 0;

  modulo_seq #(.A_WIDTH(AW), .M_WIDTH(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .modulant  (modulant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .quotient  (quotient),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level model: one op in flight, result appears m_lat cycles after accept.
  logic          m_busy = 1'b0;
  int            m_k = 0;
  int            m_lat = 0;
  logic [MW-1:0] m_res_out = '0;
  logic [AW-1:0] m_res_quo = '0;
  logic          m_res_dz = 1'b0;
  logic [MW-1:0] m_out = '0;
  logic [AW-1:0] m_quo = '0;
  logic          m_dz = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_out  = '0;
      m_quo  = '0;
      m_dz   = 1'b0;
    end else if (m_busy) begin
      if (m_k >= m_lat && out_ready) begin
        m_busy = 1'b0;
      end else begin
        m_k++;
        if (m_k == m_lat) begin
          m_out = m_res_out;
          m_quo = m_res_quo;
          m_dz  = m_res_dz;
        end
      end
    end else if (in_valid) begin
      m_busy = 1'b1;
      m_k    = 1;
      if (modulant == 0) begin
        m_res_out = '0;
        m_res_quo = {AW{1'b1}};
        m_res_dz  = 1'b1;
        m_lat     = 1;
      end else begin
        m_res_out = MW'(a % modulant);
        m_res_quo = AW'(a / modulant);
        m_res_dz  = 1'b0;
        m_lat     = (a < modulant) ? 1 : AW + 1;
      end
      if (m_k == m_lat) begin
        m_out = m_res_out;
        m_quo = m_res_quo;
        m_dz  = m_res_dz;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_in_ready", in_ready, !m_busy);
    check("cmp_out_valid", out_valid, m_busy && (m_k >= m_lat));
    check("cmp_out", out, m_out);
    check("cmp_quotient", quotient, m_quo);
    check("cmp_div_zero", div_zero, m_dz);
  end

  task automatic run_op(input logic [AW-1:0] ta, input logic [MW-1:0] tm,
                        input longint eo, input longint eq, input longint edz,
                        input int elat, input int hold, input bit poke);
    int lat;
    logic [MW-1:0] held_out;
    logic [AW-1:0] held_q;
    @(negedge clk);
    a = ta; modulant = tm; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (poke && lat == 3) begin
        check("calc_in_ready", in_ready, 0);
        a = 17'd5; modulant = 8'd3; in_valid = 1'b1;
      end
      if (poke && lat == 6) in_valid = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, elat);
    check("lit_out", out, eo);
    check("lit_quotient", quotient, eq);
    check("lit_div_zero", div_zero, edz);
    held_out = out;
    held_q = quotient;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_out", out, held_out);
      check("hold_quotient", quotient, held_q);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_out_valid", out_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_quotient", quotient, 0);
    reset = 1'b0;

    run_op(17'd12345, 8'd97, 26, 127, 0, 18, 0, 1'b1);
    run_op(17'd50, 8'd97, 50, 0, 0, 1, 0, 1'b0);
    run_op(17'd1000, 8'd0, 0, 17'h1FFFF, 1, 1, 0, 1'b0);
    run_op(17'd131071, 8'd255, 1, 514, 0, 18, 5, 1'b0);
    run_op(17'd131070, 8'd1, 0, 131070, 0, 18, 0, 1'b0);
    run_op(17'd97, 8'd97, 0, 1, 0, 18, 0, 1'b0);
    run_op(17'd96, 8'd97, 96, 0, 0, 1, 0, 1'b0);

    // Abort mid-calculation with an asynchronous reset between edges.
    @(negedge clk);
    a = 17'd12345; modulant = 8'd97; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_in_ready", in_ready, 1);
    check("async_out_valid", out_valid, 0);
    check("async_out", out, 0);
    check("async_quotient", quotient, 0);
    @(negedge clk);
    reset = 1'b0;
    run_op(17'd200, 8'd7, 4, 28, 0, 18, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
